// File: rtl/cmatrix_pkg.sv
// cmatrix_bank shared types and defaults.
// Burst modes, FSM states and width helpers.
package cmatrix_pkg;

  localparam int DEF_WORD_LEN   = 16;
  localparam int DEF_MATRIX_DIM = 8;
  localparam int DEF_NUM_MAT    = 2;

  typedef enum logic {
    MODE_ROW = 1'b0,
    MODE_COL = 1'b1
  } rd_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  // Matrix-select width never collapses to zero bits.
  function automatic int msel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmatrix_lane_mux.sv
// cmatrix_bank lane selector.
// Picks one row or column of a matrix from flat storage.
module cmatrix_lane_mux
  import cmatrix_pkg::*;
#(
  parameter  int WORD_LEN   = DEF_WORD_LEN,
  parameter  int MATRIX_DIM = DEF_MATRIX_DIM,
  parameter  int NUM_MAT    = DEF_NUM_MAT,
  localparam int IDX_BITS   = $clog2(MATRIX_DIM),
  localparam int MSEL_BITS  = msel_bits(NUM_MAT),
  localparam int MEM_BITS   =
    NUM_MAT * MATRIX_DIM * MATRIX_DIM * WORD_LEN,
  localparam int LANE_BITS  = WORD_LEN * MATRIX_DIM
) (
  input  logic [MEM_BITS-1:0]  mem_real,
  input  logic [MEM_BITS-1:0]  mem_imag,
  input  logic [MSEL_BITS-1:0] mat,
  input  rd_mode_e             mode,
  input  logic [IDX_BITS-1:0]  idx,
  output logic [LANE_BITS-1:0] lane_real,
  output logic [LANE_BITS-1:0] lane_imag
);

  function automatic int slot(
    input int       m,
    input rd_mode_e md,
    input int       ix,
    input int       lane
  );
    int addr;
    addr = (md == MODE_COL)
         ? lane * MATRIX_DIM + ix
         : ix * MATRIX_DIM + lane;
    return m * MATRIX_DIM * MATRIX_DIM + addr;
  endfunction

  // Gather lane i as M[idx][i] (rows) or M[i][idx] (columns).
  always_comb begin
    lane_real = '0;
    lane_imag = '0;
    if (int'(mat) < NUM_MAT) begin
      for (int i = 0; i < MATRIX_DIM; i++) begin
        lane_real[i*WORD_LEN +: WORD_LEN] =
          mem_real[slot(int'(mat), mode, int'(idx), i)*WORD_LEN +: WORD_LEN];
        lane_imag[i*WORD_LEN +: WORD_LEN] =
          mem_imag[slot(int'(mat), mode, int'(idx), i)*WORD_LEN +: WORD_LEN];
      end
    end
  end

endmodule

// File: rtl/cmatrix_bank.sv
// cmatrix_bank: multi-matrix complex store.
// Per-element writes, row/column burst reads.
module cmatrix_bank
  import cmatrix_pkg::*;
#(
  parameter  int WORD_LEN   = DEF_WORD_LEN,
  parameter  int MATRIX_DIM = DEF_MATRIX_DIM,
  parameter  int NUM_MAT    = DEF_NUM_MAT,
  localparam int ADDR_BITS  = $clog2(MATRIX_DIM * MATRIX_DIM),
  localparam int IDX_BITS   = $clog2(MATRIX_DIM),
  localparam int MSEL_BITS  = msel_bits(NUM_MAT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [MSEL_BITS-1:0]           wr_mat,
  input  logic [ADDR_BITS-1:0]           wr_addr,
  input  logic [WORD_LEN-1:0]            wr_real,
  input  logic [WORD_LEN-1:0]            wr_imag,
  output logic                           wr_err,
  input  logic                           rd_start,
  input  logic [MSEL_BITS-1:0]           rd_mat,
  input  logic                           rd_mode,
  output logic                           rd_busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_BITS-1:0]            out_idx,
  output logic                           out_last,
  output logic [WORD_LEN*MATRIX_DIM-1:0] out_real,
  output logic [WORD_LEN*MATRIX_DIM-1:0] out_imag
);

  localparam int ENTRIES   = MATRIX_DIM * MATRIX_DIM;
  localparam int MEM_BITS  = NUM_MAT * ENTRIES * WORD_LEN;
  localparam int LANE_BITS = WORD_LEN * MATRIX_DIM;
  localparam logic [IDX_BITS-1:0] LAST_IDX =
    IDX_BITS'(MATRIX_DIM - 1);

  logic [MEM_BITS-1:0]  mem_real;
  logic [MEM_BITS-1:0]  mem_imag;
  rd_state_e            state;
  logic [MSEL_BITS-1:0] cur_mat;
  rd_mode_e             cur_mode;
  logic                 start_ok;
  logic                 wr_bad;
  int                   wr_slot;
  logic [MSEL_BITS-1:0] sel_mat;
  rd_mode_e             sel_mode;
  logic [IDX_BITS-1:0]  sel_idx;
  logic [LANE_BITS-1:0] lane_real;
  logic [LANE_BITS-1:0] lane_imag;

  assign start_ok = (state == ST_IDLE) && rd_start
                 && (int'(rd_mat) < NUM_MAT);

  assign rd_busy = (state == ST_STREAM);

  assign wr_slot = int'(wr_mat) * ENTRIES + int'(wr_addr);

  // A write is refused when out of range or it targets the
  // matrix being streamed, including the start cycle.
  assign wr_bad = (int'(wr_mat) >= NUM_MAT)
               || (int'(wr_addr) >= ENTRIES)
               || ((state == ST_STREAM) && (wr_mat == cur_mat))
               || (start_ok && (wr_mat == rd_mat));

  // Feed the mux with what the next beat needs.
  always_comb begin
    sel_mat  = cur_mat;
    sel_mode = cur_mode;
    sel_idx  = out_idx + IDX_BITS'(1);
    if (state == ST_IDLE) begin
      sel_mat  = rd_mat;
      sel_mode = rd_mode_e'(rd_mode);
      sel_idx  = '0;
    end
  end

  cmatrix_lane_mux #(
    .WORD_LEN   (WORD_LEN),
    .MATRIX_DIM (MATRIX_DIM),
    .NUM_MAT    (NUM_MAT)
  ) u_mux (
    .mem_real  (mem_real),
    .mem_imag  (mem_imag),
    .mat       (sel_mat),
    .mode      (sel_mode),
    .idx       (sel_idx),
    .lane_real (lane_real),
    .lane_imag (lane_imag)
  );

  // Element storage and registered write-reject flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_real <= '0;
      mem_imag <= '0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= wr_en && wr_bad;
      if (wr_en && !wr_bad) begin
        mem_real[wr_slot*WORD_LEN +: WORD_LEN] <= wr_real;
        mem_imag[wr_slot*WORD_LEN +: WORD_LEN] <= wr_imag;
      end
    end
  end

  // Burst FSM with registered beat outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_mat   <= '0;
      cur_mode  <= MODE_ROW;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state     <= ST_STREAM;
            cur_mat   <= rd_mat;
            cur_mode  <= rd_mode_e'(rd_mode);
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= (MATRIX_DIM == 1);
            out_real  <= lane_real;
            out_imag  <= lane_imag;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= sel_idx;
              out_last <= (sel_idx == LAST_IDX);
              out_real <= lane_real;
              out_imag <= lane_imag;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmatrix_bank.sv
// cmatrix_bank bench: directed scenarios plus random
// bursts against an array model of the matrices.
module tb_cmatrix_bank;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int NM = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [0:0]   wr_mat;
  logic [5:0]   wr_addr;
  logic [W-1:0] wr_real;
  logic [W-1:0] wr_imag;
  logic         wr_err;
  logic         rd_start;
  logic [0:0]   rd_mat;
  logic         rd_mode;
  logic         rd_busy;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic         out_last;
  logic [W*N-1:0] out_real;
  logic [W*N-1:0] out_imag;

  always #5 clk = ~clk;

  cmatrix_bank #(
    .WORD_LEN   (W),
    .MATRIX_DIM (N),
    .NUM_MAT    (NM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_mat    (wr_mat),
    .wr_addr   (wr_addr),
    .wr_real   (wr_real),
    .wr_imag   (wr_imag),
    .wr_err    (wr_err),
    .rd_start  (rd_start),
    .rd_mat    (rd_mat),
    .rd_mode   (rd_mode),
    .rd_busy   (rd_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_real  (out_real),
    .out_imag  (out_imag)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] ref_re [NM][N*N];
  logic [W-1:0] ref_im [NM][N*N];
  logic [W-1:0] cap_re [N][N];
  logic [W-1:0] cap_im [N][N];

  int k_stall;
  int k_abort;
  bit k_rnd;
  bit k_start_wr;
  bit k_mid_wr;
  bit exp_err;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int m = 0; m < NM; m++)
      for (int a = 0; a < N*N; a++) begin
        ref_re[m][a] = '0;
        ref_im[m][a] = '0;
      end
  endtask

  task automatic tick();
    @(negedge clk);
    check("wr_err", wr_err, exp_err);
    wr_en   = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic put(
    input int           m,
    input int           a,
    input logic [W-1:0] re,
    input logic [W-1:0] im,
    input bit           rej
  );
    wr_en   = 1'b1;
    wr_mat  = 1'(m);
    wr_addr = 6'(a);
    wr_real = re;
    wr_imag = im;
    exp_err = rej;
    if (!rej) begin
      ref_re[m][a] = re;
      ref_im[m][a] = im;
    end
  endtask

  task automatic fill(input int m, input bit pattern);
    logic [W-1:0] re;
    for (int a = 0; a < N*N; a++) begin
      tick();
      if (pattern) begin
        re = 16'(((a / N) << 4) | (a % N));
        put(m, a, re, 16'hFF00 | re, 1'b0);
      end else begin
        put(m, a, 16'($urandom), 16'($urandom), 1'b0);
      end
    end
    tick();
  endtask

  task automatic stream(input int m, input bit md);
    int beat;
    int cyc;
    int stall;
    int wm;
    int a;
    bit rdy;
    bit prv_rdy;
    logic [127:0] er;
    logic [127:0] ei;
    logic [127:0] pr;
    logic [127:0] pi;
    tick();
    check("idle_valid", out_valid, 0);
    rd_start  = 1'b1;
    rd_mat    = 1'(m);
    rd_mode   = md;
    out_ready = 1'($urandom);
    if (k_start_wr) put(m, 63, 16'hABCD, 16'hABCD, 1'b1);
    beat = 0;
    cyc = 0;
    stall = 0;
    prv_rdy = 1'b1;
    pr = '0;
    pi = '0;
    while (1) begin
      tick();
      cyc++;
      rd_start = 1'($urandom);
      rd_mat   = 1'($urandom);
      rd_mode  = 1'($urandom);
      if (k_abort == beat) begin
        rst = 1'b1;
        rd_start = 1'b0;
        tick();
        check("abort_valid", out_valid, 0);
        check("abort_busy", rd_busy, 0);
        rst = 1'b0;
        clear_model();
        return;
      end
      check("valid", out_valid, 1);
      check("busy", rd_busy, 1);
      check("idx", out_idx, beat);
      check("last", out_last, beat == N-1);
      er = '0;
      ei = '0;
      for (int i = 0; i < N; i++) begin
        a = md ? i*N + beat : beat*N + i;
        er[i*W +: W] = ref_re[m][a];
        ei[i*W +: W] = ref_im[m][a];
        cap_re[beat][i] = out_real[i*W +: W];
        cap_im[beat][i] = out_imag[i*W +: W];
      end
      check("beat_real", out_real, er);
      check("beat_imag", out_imag, ei);
      if (!prv_rdy) begin
        check("hold_real", out_real, pr);
        check("hold_imag", out_imag, pi);
      end
      if (beat == k_stall && stall < 4) begin
        rdy = 1'b0;
        stall++;
      end else if (k_rnd) begin
        rdy = ($urandom % 3) != 0;
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      if (k_mid_wr && cyc == 1)
        put(m, 9, 16'h1234, 16'h1234, 1'b1);
      else if (k_mid_wr && cyc == 2)
        put(1 - m, 9, 16'h1234, 16'h1234, 1'b0);
      else if (k_rnd && ($urandom % 2) == 1) begin
        wm = int'($urandom % NM);
        put(wm, int'($urandom % (N*N)), 16'($urandom),
            16'($urandom), wm == m);
      end
      pr = out_real;
      pi = out_imag;
      prv_rdy = rdy;
      if (rdy) beat++;
      if (beat == N) break;
      if (cyc > 100) begin
        check("burst_timeout", 0, 1);
        break;
      end
    end
    tick();
    rd_start = 1'b0;
    check("end_valid", out_valid, 0);
    check("end_busy", rd_busy, 0);
    check("end_last", out_last, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_mat = '0;
    wr_addr = '0;
    wr_real = '0;
    wr_imag = '0;
    rd_start = 1'b0;
    rd_mat = '0;
    rd_mode = 1'b0;
    out_ready = 1'b0;
    exp_err = 1'b0;
    k_stall = -1;
    k_abort = -1;
    k_rnd = 1'b0;
    k_start_wr = 1'b0;
    k_mid_wr = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_err", wr_err, 0);
    check("rst_idx", out_idx, 0);
    check("rst_real", out_real, 0);
    check("rst_imag", out_imag, 0);
    rst = 1'b0;

    fill(0, 1'b1);
    fill(1, 1'b0);
    stream(0, 1'b0);
    check("t1_b2l5_re", cap_re[2][5], 16'h0025);
    check("t1_b2l5_im", cap_im[2][5], 16'hFF25);

    stream(0, 1'b1);
    check("t2_b3l6_re", cap_re[3][6], 16'h0063);
    check("t2_b7l0_re", cap_re[7][0], 16'h0007);

    k_stall = 2;
    stream(0, 1'b0);
    k_stall = -1;

    k_mid_wr = 1'b1;
    stream(0, 1'b0);
    k_mid_wr = 1'b0;
    stream(1, 1'b0);
    check("t4_m1_re", cap_re[1][1], 16'h1234);
    stream(0, 1'b0);
    check("t4_m0_re", cap_re[1][1], 16'h0011);

    k_start_wr = 1'b1;
    stream(0, 1'b0);
    k_start_wr = 1'b0;
    check("t5_b7l7_re", cap_re[7][7], 16'h0077);

    k_abort = 4;
    stream(0, 1'b0);
    k_abort = -1;
    stream(0, 1'b0);
    check("t6_zero_re", cap_re[5][3], 16'h0000);
    check("t6_zero_im", cap_im[7][7], 16'h0000);

    k_rnd = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 12; j++) begin
        tick();
        put(int'($urandom % NM), int'($urandom % (N*N)),
            16'($urandom), 16'($urandom), 1'b0);
      end
      stream(int'($urandom % NM), 1'($urandom));
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
